// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP MAC sequencer: FSM state encoding,
// DSP opmode values and the tag-to-opmode decode.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  localparam logic [7:0] OPM_CLR  = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC  = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_IDLE = 8'h00;

  // The first product of a job clears the accumulator; later ones add to P.
  function automatic logic [7:0] opm_decode(input logic valid, input logic first);
    logic [7:0] opm;
    if (!valid) begin
      opm = OPM_IDLE;
    end else if (first) begin
      opm = OPM_CLR;
    end else begin
      opm = OPM_ACC;
    end
    return opm;
  endfunction

endpackage

// File: rtl/seq_delay_line.sv
// Fixed-depth shift register for per-cycle tags; DEPTH=0 is a plain wire.
// Asynchronous active-high reset clears every stage.
module seq_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift chain: stage 0 captures d, each later stage takes its predecessor.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
          end
        end else begin
          stage_r[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign q = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mac_seq_ctrl.sv
// Operand/opmode sequencer for a DSP-slice multiply-accumulate job.
// Optional output backpressure: define MAC_SEQ_BACKPRESSURE_EN to add out_ready.
module mac_seq_ctrl
  import dsp_seq_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int OPM_DLY  = 2,
  parameter int PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce_ab,
  output logic [7:0]       opmode,
  output logic             ce_p,
  output logic             out_valid,
  output logic             done,
  output logic             busy,
  output logic             len_err
`ifdef MAC_SEQ_BACKPRESSURE_EN
  ,
  input  logic             out_ready
`endif
);

  localparam logic [LEN_W-1:0] LEN_ZERO   = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       DRAIN_INIT = 4'(PIPE_LAT - 1);
  localparam logic [3:0]       DRAIN_ONE  = 4'd1;

  seq_state_e       state_r, state_s;
  logic [LEN_W-1:0] remaining_r, remaining_s;
  logic [3:0]       drain_r, drain_s;
  logic             first_r, first_s;
  logic             len_err_r, len_err_s;
  logic             done_s;
  logic             accept_s;
  logic [1:0]       tag_s, tag_dly_s;
  logic [7:0]       opmode_r;
  logic             ce_p_r;

  assign in_ready = (state_r == ST_RUN);
  assign accept_s = in_valid & in_ready;
  assign ce_ab    = accept_s;
  assign tag_s    = {accept_s, accept_s & first_r};

  // FSM state and job counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      remaining_r <= LEN_ZERO;
      drain_r     <= 4'd0;
      first_r     <= 1'b0;
      len_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      drain_r     <= drain_s;
      first_r     <= first_s;
      len_err_r   <= len_err_s;
    end
  end

  // Next-state logic; done fires in the HOLD cycle that returns to IDLE.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    drain_s     = drain_r;
    first_s     = first_r;
    len_err_s   = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (len != LEN_ZERO)) begin
          remaining_s = len;
          first_s     = 1'b1;
          state_s     = ST_RUN;
        end else if (start) begin
          len_err_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          remaining_s = remaining_r - LEN_ONE;
          first_s     = 1'b0;
          if (remaining_r == LEN_ONE) begin
            drain_s = DRAIN_INIT;
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // HOLD is reached exactly PIPE_LAT cycles after the last accept.
        drain_s = drain_r - DRAIN_ONE;
        if (drain_r <= DRAIN_ONE) begin
          drain_s = 4'd0;
          state_s = ST_HOLD;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
`ifdef MAC_SEQ_BACKPRESSURE_EN
        if (out_ready) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
`else
        done_s  = 1'b1;
        state_s = ST_IDLE;
`endif
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // The output register below supplies the final cycle of the OPM_DLY delay.
  seq_delay_line #(
    .DEPTH(OPM_DLY - 1),
    .WIDTH(2)
  ) u_tag_dly (
    .clk(clk),
    .rst(rst),
    .d  (tag_s),
    .q  (tag_dly_s)
  );

  // Registered DSP controls decoded from the delayed tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opmode_r <= OPM_IDLE;
      ce_p_r   <= 1'b0;
    end else begin
      opmode_r <= opm_decode(tag_dly_s[1], tag_dly_s[0]);
      ce_p_r   <= tag_dly_s[1];
    end
  end

  assign opmode    = opmode_r;
  assign ce_p      = ce_p_r;
  assign out_valid = (state_r == ST_HOLD);
  assign busy      = (state_r != ST_IDLE);
  assign done      = done_s;
  assign len_err   = len_err_r;

endmodule
